down_timer8b: RTL



---
 rtl/down_timer8b_pkg.sv | 22 ++
 rtl/decrementer8b.sv | 19 +
 rtl/down_timer8b_tick_gen.sv | 53 +++++
 rtl/down_timer8b.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/down_timer8b_pkg.sv
// -----------------------------------------------------------------------------
// down_timer8b_pkg
// Shared definitions for the down_timer8b slice: data width, FSM state
// encoding and the prescaler width helper used by tick_gen.
// -----------------------------------------------------------------------------
package down_timer8b_pkg;

  localparam int TIMER_W = 8;

  // 2'b11 is not a legal state; the FSM recovers from it to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Prescaler counter width: clog2(PRESCALE), never narrower than one bit.
  function automatic int prescale_w(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/decrementer8b.sv
// -----------------------------------------------------------------------------
// decrementer8b
// Combinational 8-bit decrement-by-one.
// Ports:
//   a      in  8  operand
//   d      out 8  a - 1 (wraps 0x00 -> 0xFF)
//   borrow out 1  high when a == 0x00
// -----------------------------------------------------------------------------
module decrementer8b (
  input  logic [7:0] a,
  output logic [7:0] d,
  output logic       borrow
);

  always_comb begin
    {borrow, d} = {1'b0, a} - 9'd1;
  end

endmodule

// File: rtl/down_timer8b_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Prescaler for down_timer8b: emits one tick every PRESCALE enabled,
// non-held cycles.
// Ports:
//   clk   in  1  system clock
//   rst   in  1  synchronous active-high reset
//   clr   in  1  force the prescaler back to zero
//   en    in  1  counting enabled (timer is running)
//   hold  in  1  freeze the prescaler and suppress the tick
//   tick  out 1  combinational tick, high in the last prescaler slot
// -----------------------------------------------------------------------------
module tick_gen
  import down_timer8b_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic hold,
  output logic tick
);

  localparam int            PW   = prescale_w(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  always_comb begin
    tick  = en && !hold && (pre_q == LAST);
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      if (tick) begin
        pre_d = '0;
      end else if (!hold) begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/down_timer8b.sv
// -----------------------------------------------------------------------------
// down_timer8b
// Loadable 8-bit count-down timer around decrementer8b, with a prescaled
// tick, start/pause/done handshake, single-step in IDLE and sticky underflow.
// Optional build macro: DOWN_TIMER8B_AUTO_RELOAD_EN adds a reload register
// (captured on every load) that restarts the countdown instead of finishing.
// Ports:
//   clk       in  1  system clock
//   rst       in  1  synchronous active-high reset
//   load      in  1  write load_val into count (priority below rst)
//   load_val  in  8  value written on load
//   start     in  1  begin countdown (IDLE only)
//   pause     in  1  freeze count and prescaler while running
//   step      in  1  single decrement in IDLE, wrap allowed
//   count     out 8  current count
//   busy      out 1  high while running
//   done      out 1  one-cycle completion pulse
//   underflow out 1  sticky: a committed decrement borrowed
// -----------------------------------------------------------------------------
module down_timer8b
  import down_timer8b_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               start,
  input  logic               pause,
  input  logic               step,
  output logic [TIMER_W-1:0] count,
  output logic               busy,
  output logic               done,
  output logic               underflow
);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               unf_q, unf_d;
  logic               pre_clr;
  logic               tick;
  logic [TIMER_W-1:0] dec_d;
  logic               dec_borrow;
`ifdef DOWN_TIMER8B_AUTO_RELOAD_EN
  logic [TIMER_W-1:0] reload_q, reload_d;
`endif

  decrementer8b u_dec (
    .a      (count_q),
    .d      (dec_d),
    .borrow (dec_borrow)
  );

  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (state_q == ST_RUN),
    .hold (pause),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unf_d   = unf_q;
    pre_clr = 1'b0;
    done_d  = 1'b0;
`ifdef DOWN_TIMER8B_AUTO_RELOAD_EN
    reload_d = load ? load_val : reload_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          count_d = load_val;
          unf_d   = 1'b0;
        end else if (start) begin
          pre_clr = 1'b1;
          // Starting from zero skips the countdown and finishes immediately.
          state_d = (count_q != '0) ? ST_RUN : ST_DONE;
        end else if (step) begin
          count_d = dec_d;
          unf_d   = unf_q | dec_borrow;
        end
      end
      ST_RUN: begin
        if (load) begin
          // Abort: no done pulse.
          count_d = load_val;
          state_d = ST_IDLE;
        end else if (tick) begin
          count_d = dec_d;
          unf_d   = unf_q | dec_borrow;
          if (count_q == TIMER_W'(1)) begin
`ifdef DOWN_TIMER8B_AUTO_RELOAD_EN
            if (reload_q != '0) begin
              // Restart in place: pulse done but never leave RUN.
              count_d = reload_q;
              done_d  = 1'b1;
            end else begin
              state_d = ST_DONE;
            end
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (load) begin
          count_d = load_val;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = done_d | (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      unf_q    <= 1'b0;
`ifdef DOWN_TIMER8B_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      unf_q    <= unf_d;
`ifdef DOWN_TIMER8B_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign count     = count_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign underflow = unf_q;

endmodule
